hazard3_operand_fetch: RTL and testbench
========================================

# hazard3_operand_fetch

Operand-fetch stage that drives the read side of the 1-write/2-read register file and returns resolved source operands to the execute stage. The register file reads synchronously, so a read issued in cycle N returns in cycle N+1 with the value from before any cycle-N write. This block issues the read addresses, forwards same-cycle and later writebacks, holds operands across downstream stalls, and presents them through a valid/ready handshake.

## Interface
Parameters:
- W_DATA, 32, operand and register width
- W_ADDR, 5, register address width
- ZERO_X0, 1, if 1 then address 0 always reads zero and writes to address 0 are never forwarded

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  upstream has a fetch request
- in_ready  output  1  block accepts a request this cycle
- in_rs1  input  W_ADDR  source register 1 address
- in_rs2  input  W_ADDR  source register 2 address
- rf_raddr1  output  W_ADDR  to regfile raddr1
- rf_raddr2  output  W_ADDR  to regfile raddr2
- rf_rdata1  input  W_DATA  from regfile rdata1, valid the cycle after issue
- rf_rdata2  input  W_DATA  from regfile rdata2
- wb_wen  input  1  writeback enable, the same signal that drives the regfile wen
- wb_waddr  input  W_ADDR  writeback address
- wb_wdata  input  W_DATA  writeback data
- out_valid  output  1  operands valid
- out_ready  input  1  downstream consumes operands
- out_rs1  output  W_ADDR  register address of the operands currently presented
- out_rs2  output  W_ADDR
- out_op1  output  W_DATA  resolved operand 1
- out_op2  output  W_DATA  resolved operand 2

## Operation
- Address path: rf_raddr1/2 = in_rs1/2, combinational and unconditional.
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready, so the stage is single-entry with no skid.
- State encoding: out_valid flag plus src_fresh flag.
- State EMPTY: out_valid = 0.
- State FRESH: entered the cycle after an accept. Operand source is rf_rdata, or the bypass register if there is a bypass hit.
- State HELD: entered when FRESH or HELD is not consumed. Operand source is the hold registers.
- Transitions:
  - accept -> FRESH, from any state.
  - out_valid && !out_ready -> HELD.
  - consume without a new accept -> EMPTY.
- Bypass capture: at accept, for each operand latch hit = wb_wen && wb_waddr == in_rsN, and latch wb_wdata. A FRESH operand uses the bypass data when hit is set, otherwise rf_rdata.
- Hold capture: at the end of any cycle with out_valid && !out_ready, hold_opN <= (wb_wen && wb_waddr == out_rsN) ? wb_wdata : the currently presented out_opN.
- A write in the presentation cycle is not reflected in out_op that cycle. It is reflected from the next cycle if the operands are still presented.
- x0 (ZERO_X0=1): when the register address is 0, out_op is 0 and bypass/hold hits are suppressed.
- out_op1/2 = 0 whenever out_valid = 0.
- Both operands resolve independently. rs1 == rs2 yields identical values.

## Timing
- Reset (async): out_valid=0, out_rs1/2=0, out_op1/2=0. Hold and bypass registers cleared. in_ready=1. Any in-flight operation is dropped.
- Latency: accept in cycle N produces out_valid in cycle N+1. Throughput is 1 per cycle when out_ready is held high.
- Write in cycle N to a source register of the request accepted in cycle N: cycle N+1 presents wb_wdata, not the stale rf_rdata.
- Write in cycle N-1 or earlier: already in the regfile, read normally.
- Stall lasting k cycles: operands are refreshed by every matching write during the stall. The value presented equals the register state at the start of each cycle.
- Accept and consume in the same cycle: the old operands retire and the new operands appear in the next cycle as FRESH. No bubble.
- Multiple writes to the same register during a stall: the last write wins.
- Reset deasserted mid-stall: the block restarts in EMPTY.

## Test plan
- Reset, then request rs1=3, rs2=4 with regs x3=0x11, x4=0x22 and out_ready=1 -> out_valid in the next cycle, op1=0x11, op2=0x22. Back-to-back requests each get 1-cycle latency.
- Same-cycle hazard: accept rs1=5 while wb writes x5=0xDEAD (regfile previously 0x1) -> next cycle op1=0xDEAD.
- Stall: accept rs1=6, rs2=6; hold out_ready=0 for 3 cycles; write x6=0xBEEF in the second stall cycle -> op1=op2=old value until the cycle after the write, then 0xBEEF. in_ready=0 throughout the stall. Releasing out_ready consumes 0xBEEF.
- x0: rs1=0 with wb writing x0=0xFFFF in the same cycle -> op1=0. With ZERO_X0=0 -> op1=0xFFFF.
- Accept and consume in the same cycle with out_ready=1 and a continuous in_valid stream of 8 requests -> 8 consecutive out_valid cycles with no bubble and correct operands.
- Assert rst_n low while in HELD -> out_valid=0 and out_op=0 immediately. After release the first accept is returned correctly.

Source files
------------

// File: rtl/hazard3_operand_fetch.sv
// Operand fetch: issues regfile reads, forwards writebacks into fresh and
// stalled operands, and presents them through a single-entry valid/ready stage.
module hazard3_operand_fetch #(
  parameter int W_DATA  = 32,
  parameter int W_ADDR  = 5,
  parameter int ZERO_X0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_ADDR-1:0] in_rs1,
  input  logic [W_ADDR-1:0] in_rs2,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  input  logic [W_DATA-1:0] rf_rdata1,
  input  logic [W_DATA-1:0] rf_rdata2,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_ADDR-1:0] out_rs1,
  output logic [W_ADDR-1:0] out_rs2,
  output logic [W_DATA-1:0] out_op1,
  output logic [W_DATA-1:0] out_op2
);

  // EMPTY: !out_valid | FRESH: out_valid & src_fresh (regfile/bypass) |
  // HELD: out_valid & !src_fresh (hold registers)
  logic              src_fresh;
  logic              byp_hit1, byp_hit2;
  logic [W_DATA-1:0] byp_data1, byp_data2;
  logic [W_DATA-1:0] hold_op1, hold_op2;
  logic              accept;
  logic              in_hit1, in_hit2, out_hit1, out_hit2;

  function automatic logic is_x0(input logic [W_ADDR-1:0] a);
    return (ZERO_X0 != 0) && (a == '0);
  endfunction

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign in_hit1  = wb_wen && (wb_waddr == in_rs1)  && !is_x0(in_rs1);
  assign in_hit2  = wb_wen && (wb_waddr == in_rs2)  && !is_x0(in_rs2);
  assign out_hit1 = wb_wen && (wb_waddr == out_rs1) && !is_x0(out_rs1);
  assign out_hit2 = wb_wen && (wb_waddr == out_rs2) && !is_x0(out_rs2);

  always_comb begin
    out_op1 = '0;
    out_op2 = '0;
    if (out_valid) begin
      if (!is_x0(out_rs1))
        out_op1 = src_fresh ? (byp_hit1 ? byp_data1 : rf_rdata1) : hold_op1;
      if (!is_x0(out_rs2))
        out_op2 = src_fresh ? (byp_hit2 ? byp_data2 : rf_rdata2) : hold_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      src_fresh <= 1'b0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      byp_hit1  <= 1'b0;
      byp_hit2  <= 1'b0;
      byp_data1 <= '0;
      byp_data2 <= '0;
      hold_op1  <= '0;
      hold_op2  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      src_fresh <= 1'b1;
      out_rs1   <= in_rs1;
      out_rs2   <= in_rs2;
      byp_hit1  <= in_hit1;
      byp_hit2  <= in_hit2;
      byp_data1 <= wb_wdata;
      byp_data2 <= wb_wdata;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      src_fresh <= 1'b0;
    end else if (out_valid) begin
      // Stalled: fold this cycle's writeback in so next cycle shows current state
      src_fresh <= 1'b0;
      hold_op1  <= out_hit1 ? wb_wdata : out_op1;
      hold_op2  <= out_hit2 ? wb_wdata : out_op2;
    end
  end

endmodule

// File: tb/tb_hazard3_operand_fetch.sv
// Directed bench for hazard3_operand_fetch with a behavioural synchronous-read
// regfile; a second instance covers ZERO_X0=0.
module tb_hazard3_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, b_in_ready;
  logic [4:0]  in_rs1, in_rs2;
  logic [4:0]  rf_raddr1, rf_raddr2, b_raddr1, b_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid, b_out_valid, out_ready;
  logic [4:0]  out_rs1, out_rs2, b_out_rs1, b_out_rs2;
  logic [31:0] out_op1, out_op2, b_op1, b_op2;
  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
    if (wb_wen) regs[wb_waddr] <= wb_wdata;
  end

  hazard3_operand_fetch #(.W_DATA(32), .W_ADDR(5), .ZERO_X0(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_op1(out_op1), .out_op2(out_op2)
  );

  hazard3_operand_fetch #(.W_DATA(32), .W_ADDR(5), .ZERO_X0(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .rf_raddr1(b_raddr1), .rf_raddr2(b_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_op1(b_op1), .out_op2(b_op2)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ordy;
    logic        e_ov, e_ir;
    logic [31:0] e_op1, e_op2, e_op1b;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ordy, input logic e_ov, input logic e_ir,
                              input logic [31:0] e_op1, input logic [31:0] e_op2,
                              input logic [31:0] e_op1b);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.wen = wen; v.wa = wa; v.wd = wd;
    v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir;
    v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_op1b = e_op1b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ordy);
    in_valid = iv; in_rs1 = rs1; in_rs2 = rs2;
    wb_wen = wen; wb_waddr = wa; wb_wdata = wd; out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);

    // Preload the regfile through the write port while the DUTs are in reset
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 5'(i), (i == 0) ? 32'h0 : 32'h100 + 32'(i), 1);
      next_cycle();
    end
    drive(0, 0, 0, 1, 3, 32'h11, 1); next_cycle();
    drive(0, 0, 0, 1, 4, 32'h22, 1); next_cycle();
    drive(0, 0, 0, 1, 5, 32'h1,  1); next_cycle();
    drive(0, 0, 0, 1, 6, 32'h66, 1); next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_op1", out_op1, 0);
    chk("rst_op2", out_op2, 0);
    chk("rst_rs1", 32'(out_rs1), 0);
    chk("rst_rs2", 32'(out_rs2), 0);
    rst_n = 1'b1;
    next_cycle();

    //              iv rs1 rs2 wen wa wd            ordy ov ir op1           op2           op1b
    vecs[0]  = mk(1, 3, 4, 0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h0);
    vecs[1]  = mk(1, 4, 3, 0, 0, 32'h0,        1, 1, 1, 32'h11,       32'h22,       32'h11);
    vecs[2]  = mk(1, 5, 0, 1, 5, 32'hDEAD,     1, 1, 1, 32'h22,       32'h11,       32'h22);
    vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'hDEAD,     32'h0,        32'hDEAD);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h0);
    vecs[5]  = mk(1, 6, 6, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0,        32'h0);
    vecs[6]  = mk(0, 6, 6, 0, 0, 32'h0,        0, 1, 0, 32'h66,       32'h66,       32'h66);
    vecs[7]  = mk(1, 3, 3, 1, 6, 32'hBEEF,     0, 1, 0, 32'h66,       32'h66,       32'h66);
    vecs[8]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hBEEF,     32'hBEEF,     32'hBEEF);
    vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'hBEEF,     32'hBEEF,     32'hBEEF);
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h0);
    vecs[11] = mk(1, 0, 7, 1, 0, 32'hFFFF,     1, 0, 1, 32'h0,        32'h0,        32'h0);
    vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        32'h107,      32'hFFFF);
    vecs[13] = mk(1, 7, 8, 1, 8, 32'hCAFE,     1, 0, 1, 32'h0,        32'h0,        32'h0);
    vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h107,      32'hCAFE,     32'h107);
    vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].wen, vecs[i].wa, vecs[i].wd,
            vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_op1", i), out_op1, vecs[i].e_op1);
      chk($sformatf("v%0d_op2", i), out_op2, vecs[i].e_op2);
      chk($sformatf("v%0d_raddr1", i), 32'(rf_raddr1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_raddr2", i), 32'(rf_raddr2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_b_raddr", i), {b_raddr1, b_raddr2}, {vecs[i].rs1, vecs[i].rs2});
      chk($sformatf("v%0d_b_valid", i), 32'(b_out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_b_ready", i), 32'(b_in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_b_op1", i), b_op1, vecs[i].e_op1b);
      chk($sformatf("v%0d_b_op2", i), b_op2, vecs[i].e_op2);
      next_cycle();
    end

    // Back-to-back stream of 8 requests over untouched registers x9..x15
    for (int k = 0; k <= 9; k++) begin
      if (k < 8) drive(1, 5'(9 + k % 7), 5'(15 - k % 7), 0, 0, 0, 1);
      else       drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      if (k == 0 || k == 9) begin
        chk($sformatf("s%0d_out_valid", k), 32'(out_valid), 0);
      end else begin
        chk($sformatf("s%0d_out_valid", k), 32'(out_valid), 1);
        chk($sformatf("s%0d_op1", k), out_op1, 32'h100 + 32'(9 + (k - 1) % 7));
        chk($sformatf("s%0d_op2", k), out_op2, 32'h100 + 32'(15 - (k - 1) % 7));
      end
      next_cycle();
    end

    // Successive writes during a stall: each one shows up the following cycle
    drive(1, 10, 11, 0, 0, 0, 0);
    @(negedge clk); chk("lw_a_valid", 32'(out_valid), 0); next_cycle();
    drive(0, 0, 0, 1, 10, 32'hA1, 0);
    @(negedge clk);
    chk("lw_b_op1", out_op1, 32'h10A);
    chk("lw_b_op2", out_op2, 32'h10B);
    next_cycle();
    drive(0, 0, 0, 1, 10, 32'hA2, 0);
    @(negedge clk);
    chk("lw_c_op1", out_op1, 32'hA1);
    chk("lw_c_ready", 32'(in_ready), 0);
    next_cycle();
    drive(0, 0, 0, 1, 11, 32'hB1, 1);
    @(negedge clk);
    chk("lw_d_op1", out_op1, 32'hA2);
    chk("lw_d_op2", out_op2, 32'h10B);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("lw_e_valid", 32'(out_valid), 0); next_cycle();

    // x0 hold suppression, then async reset while HELD
    drive(1, 0, 12, 0, 0, 0, 0);
    @(negedge clk); chk("hr_a_valid", 32'(out_valid), 0); next_cycle();
    drive(0, 0, 0, 1, 0, 32'h55, 0);
    @(negedge clk);
    chk("hr_b_op1", out_op1, 0);
    chk("hr_b_op2", out_op2, 32'h10C);
    chk("hr_b_b_op1", b_op1, 32'hFFFF);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("hr_c_valid", 32'(out_valid), 1);
    chk("hr_c_op1", out_op1, 0);
    chk("hr_c_op2", out_op2, 32'h10C);
    chk("hr_c_b_op1", b_op1, 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("hr_rst_valid", 32'(out_valid), 0);
    chk("hr_rst_ready", 32'(in_ready), 1);
    chk("hr_rst_op2", out_op2, 0);
    chk("hr_rst_rs2", 32'(out_rs2), 0);
    chk("hr_rst_b", {b_out_valid, b_out_rs1, b_out_rs2}, 0);
    chk("hr_rst_b_op", b_op1 | b_op2, 0);
    next_cycle();
    rst_n = 1'b1;
    drive(1, 13, 14, 0, 0, 0, 1);
    @(negedge clk); chk("hr_d_valid", 32'(out_valid), 0); next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("hr_e_valid", 32'(out_valid), 1);
    chk("hr_e_op1", out_op1, 32'h10D);
    chk("hr_e_op2", out_op2, 32'h10E);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
